// File: rtl/fifo_wr_arbiter_if.sv
// Shared FIFO write-port bundle: requester handshakes on one side, FIFO write
// strobe/data/full on the other. The master modport is the arbiter's view.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8
) ();

  logic              en;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      gnt;
  logic              busy;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_din;

  modport master (
    input  en,
    input  req_valid,
    input  req_data,
    input  fifo_full,
    output req_ready,
    output gnt,
    output busy,
    output fifo_wr,
    output fifo_din
  );

  modport slave (
    output en,
    output req_valid,
    output req_data,
    output fifo_full,
    input  req_ready,
    input  gnt,
    input  busy,
    input  fifo_wr,
    input  fifo_din
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready
// requesters. A grant lasts up to MAX_BURST beats; writes are gated by the
// FIFO full flag so nothing is ever written into a full FIFO.
module fifo_wr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            pick_found;
  logic [PtrW-1:0] pick_idx;
  logic [N-1:0]    pick_oh;
  logic [PtrW-1:0] ptr_nxt;
  logic            granted_valid;
  logic            beat;
  logic            last_beat;
  logic [DW-1:0]   din_mux;

  // Round-robin pick: first valid requester starting at ptr_q, wrapping mod N.
  always_comb begin
    int unsigned     cand;
    logic [PtrW-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = PtrW'(cand);
      if (!pick_found && bus.req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // One-hot of the winner and the pointer just past it (winner gets lowest priority next).
  always_comb begin
    int unsigned nxt;
    pick_oh = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    nxt     = 32'(pick_idx) + 32'd1;
    if (nxt >= N) nxt = 0;
    ptr_nxt = PtrW'(nxt);
  end

  // Write-port outputs are combinational from the registered grant.
  always_comb begin
    granted_valid = |(gnt_q & bus.req_valid);
    beat          = granted_valid & ~bus.fifo_full;
    last_beat     = beat && (({1'b0, cnt_q} + 5'd1) == 5'(MAX_BURST));
    din_mux       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) din_mux = din_mux | bus.req_data[i*DW +: DW];
    end
  end

  assign bus.fifo_wr   = beat;
  assign bus.fifo_din  = din_mux;
  assign bus.req_ready = bus.fifo_full ? '0 : gnt_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q == StBusy);

  // Next state: grant from idle, count beats, release and re-grant on the same edge.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.en && pick_found) begin
          state_d = StBusy;
          gnt_d   = pick_oh;
          ptr_d   = ptr_nxt;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (!granted_valid || last_beat) begin
          // ptr_q already points past the releasing owner.
          if (bus.en && pick_found) begin
            gnt_d = pick_oh;
            ptr_d = ptr_nxt;
            cnt_d = '0;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
